inst_encoder: RTL

- Inverse of the immediate generator: packs decoded fields and a 32-bit immediate back into a standard RV32I instruction word.
- Supported formats: I, I-zero-extended, shift-immediate, S, B, U and J.
- Used by the bench/boot program loader to stream instruction words into instruction memory.
- Valid/ready input, 2-entry output FIFO, running write address, optional immediate range checking.

---
 rtl/inst_encoder.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/inst_encoder.sv
// inst_encoder
//   Packs decoded RV32I fields plus a 32-bit immediate back into an
//   instruction word. Words are queued in a 2-entry FIFO together with a
//   running byte address, so a loader can stream them into instruction memory.
//
// Optional feature macro: INST_ENCODER_RANGE_CHECK_EN
//   Defined   : immediates are range checked; out_err / err_cnt report failures.
//   Undefined : no checking; out_err and err_cnt read 0, err_clr is ignored.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   request handshake (ready while fewer than 2 queued)
//   fmt                   0 I, 1 I-zext, 2 shift-imm, 3 S, 4 B, 5 U, 6 J, 7 invalid
//   opcode, rd, rs1, rs2, funct3, funct7, imm   instruction fields
//   out_valid / out_ready head-of-FIFO handshake
//   out_inst, out_addr    encoded word and its byte address
//   out_err               head entry failed its range check
//   err_clr, err_cnt      clear / saturating count of range errors
module inst_encoder #(
    parameter int                 ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    input  logic              err_clr,
    output logic [7:0]        err_cnt
);

    logic [31:0]       enc_inst;
    logic              enc_err;
    logic              push;
    logic              pop;

    logic [31:0]       entry_inst_q [2];
    logic [31:0]       entry_inst_d [2];
    logic [ADDR_W-1:0] entry_addr_q [2];
    logic [ADDR_W-1:0] entry_addr_d [2];
    logic [1:0]        entry_err_q;
    logic [1:0]        entry_err_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;

    // Instruction packing; anything unrecognised becomes a NOP (addi x0,x0,0).
    always_comb begin
        enc_inst = 32'h0000_0013;
        case (fmt)
            3'd0, 3'd1: enc_inst = {imm[11:0], rs1, funct3, rd, opcode};
            3'd2:       enc_inst = {funct7, imm[4:0], rs1, funct3, rd, opcode};
            3'd3:       enc_inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            3'd4:       enc_inst = {imm[12], imm[10:5], rs2, rs1, funct3,
                                    imm[4:1], imm[11], opcode};
            3'd5:       enc_inst = {imm[31:12], rd, opcode};
            3'd6:       enc_inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default:    enc_inst = 32'h0000_0013;
        endcase
    end

`ifdef INST_ENCODER_RANGE_CHECK_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // An immediate is in range when the bits the format drops are pure sign
    // (or zero) extension of what it keeps, and dropped low bits are zero.
    always_comb begin
        enc_err = 1'b1;
        case (fmt)
            3'd0, 3'd3: enc_err = (imm[31:11] != {21{imm[11]}});
            3'd1:       enc_err = (imm[31:12] != 20'd0);
            3'd2:       enc_err = (imm[31:5]  != 27'd0);
            3'd4:       enc_err = imm[0] || (imm[31:12] != {20{imm[12]}});
            3'd5:       enc_err = (imm[11:0]  != 12'd0);
            3'd6:       enc_err = imm[0] || (imm[31:20] != {12{imm[20]}});
            default:    enc_err = 1'b1;
        endcase
    end

    // Clear wins over a same-cycle increment; the count sticks at 255.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = 8'd0;
        end else if (push && enc_err && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign enc_err        = 1'b0;
    assign err_cnt        = 8'd0;
`endif

    // Readiness comes only from the registered count: a full FIFO does not
    // accept even when the head is being popped in the same cycle.
    assign in_ready  = (count_q < 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // FIFO and address-counter next state.
    always_comb begin
        entry_inst_d = entry_inst_q;
        entry_addr_d = entry_addr_q;
        entry_err_d  = entry_err_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        wr_addr_d    = wr_addr_q;
        if (push) begin
            entry_inst_d[wr_ptr_q] = enc_inst;
            entry_addr_d[wr_ptr_q] = wr_addr_q;
            entry_err_d[wr_ptr_q]  = enc_err;
            wr_ptr_d               = ~wr_ptr_q;
            wr_addr_d              = wr_addr_q + ADDR_W'(4);
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + 2'(push) - 2'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                entry_inst_q[i] <= 32'd0;
                entry_addr_q[i] <= BASE_ADDR;
            end
            entry_err_q <= 2'b00;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            wr_addr_q   <= BASE_ADDR;
        end else begin
            entry_inst_q <= entry_inst_d;
            entry_addr_q <= entry_addr_d;
            entry_err_q  <= entry_err_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            wr_addr_q    <= wr_addr_d;
        end
    end

    // An empty FIFO presents the idle values rather than a stale entry.
    assign out_inst = out_valid ? entry_inst_q[rd_ptr_q] : 32'd0;
    assign out_addr = out_valid ? entry_addr_q[rd_ptr_q] : BASE_ADDR;
    assign out_err  = out_valid ? entry_err_q[rd_ptr_q]  : 1'b0;

endmodule
